// File: rtl/idli_ex_slice_m.sv
// idli_ex_slice_m: slice-serial execute datapath.
// A DATA_W-bit operation is processed as DATA_W/SLICE_W slices, starting with
// the LSB slice. The carry is chained from one slice to the next and the zero
// flag accumulates across slices. N/C/V and the predicate compare are valid on
// the final slice.
// Optional feature: define IDLI_EX_SLICE_STALL_EN to honour i_ex_stall. When
// the macro is undefined the stall input is ignored, but the port must still
// be tied.
//
// state | meaning
// IDLE  | no op in flight; any incoming op is accepted
// RUN   | latched op in flight; one slice per unstalled cycle
module idli_ex_slice_m #(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4,
  parameter int CTR_W   = $clog2(DATA_W / SLICE_W)
) (
  input  logic               i_ex_gck,
  input  logic               i_ex_rst_n,
  input  logic               i_ex_op_vld,
  output logic               o_ex_op_acp,
  input  logic               i_ex_pred,
  input  logic [1:0]         i_ex_alu_op,
  input  logic               i_ex_rhs_inv,
  input  logic               i_ex_cin,
  input  logic [1:0]         i_ex_cmp_op,
  input  logic               i_ex_cmp_signed,
  input  logic [SLICE_W-1:0] i_ex_lhs,
  input  logic [SLICE_W-1:0] i_ex_rhs,
  input  logic               i_ex_stall,
  output logic [SLICE_W-1:0] o_ex_out,
  output logic               o_ex_out_vld,
  output logic [CTR_W-1:0]   o_ex_ctr,
  output logic               o_ex_last,
  output logic [3:0]         o_ex_flags,
  output logic               o_ex_cmp
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NUM_SLICES - 1);

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] CMP_EQ  = 2'd0;
  localparam logic [1:0] CMP_NE  = 2'd1;
  localparam logic [1:0] CMP_LT  = 2'd2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q;
  logic             carry_q;
  logic             z_q;
  logic [1:0]       alu_op_q;
  logic             rhs_inv_q;
  logic             cin_q;
  logic [1:0]       cmp_op_q;
  logic             cmp_signed_q;

  logic stall;
  logic busy;
  logic last;
  logic advance;
  logic accept;
  logic launch;

`ifdef IDLI_EX_SLICE_STALL_EN
  assign stall = i_ex_stall;
`else
  logic unused_stall;
  assign unused_stall = i_ex_stall;
  assign stall        = 1'b0;
`endif

  assign busy    = (state_q == RUN);
  assign last    = busy && (ctr_q == CTR_LAST);
  assign advance = busy && !stall;
  // A new op may enter on the final unstalled slice, so issue has no bubble.
  assign accept  = i_ex_op_vld && o_ex_op_acp;
  assign launch  = accept && i_ex_pred;

  // Next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    o_ex_op_acp  = !busy || (last && !stall);
    o_ex_out_vld = advance;
    o_ex_last    = last;
    o_ex_ctr     = ctr_q;
    if (advance && last) state_d = IDLE;
    if (launch)          state_d = RUN;
  end

  // Slice datapath: chained carry, sign-bit carry-in for overflow, flags and compare
  logic [SLICE_W-1:0] rhs_x;
  logic               cin_eff;
  logic [SLICE_W:0]   sum;
  logic [SLICE_W-1:0] low;
  logic               cout;
  logic               sign_cin;
  logic               flag_z, flag_n, flag_c, flag_v;

  always_comb begin
    rhs_x    = rhs_inv_q ? ~i_ex_rhs : i_ex_rhs;
    cin_eff  = (ctr_q == '0) ? cin_q : carry_q;
    sum      = {1'b0, i_ex_lhs} + {1'b0, rhs_x} + {{SLICE_W{1'b0}}, cin_eff};
    low      = {1'b0, i_ex_lhs[SLICE_W-2:0]} + {1'b0, rhs_x[SLICE_W-2:0]}
             + {{(SLICE_W-1){1'b0}}, cin_eff};
    o_ex_out = sum[SLICE_W-1:0];
    cout     = 1'b0;
    sign_cin = 1'b0;
    case (alu_op_q)
      ALU_ADD: begin
        cout     = sum[SLICE_W];
        sign_cin = low[SLICE_W-1];
      end
      ALU_AND: o_ex_out = i_ex_lhs & rhs_x;
      ALU_OR:  o_ex_out = i_ex_lhs | rhs_x;
      default: o_ex_out = i_ex_lhs ^ rhs_x;
    endcase
    flag_z     = z_q && (o_ex_out == '0);
    flag_n     = o_ex_out[SLICE_W-1];
    flag_c     = cout;
    flag_v     = (alu_op_q == ALU_ADD) ? (sign_cin ^ cout) : 1'b0;
    o_ex_flags = {flag_z, flag_n, flag_c, flag_v};
    case (cmp_op_q)
      CMP_EQ:  o_ex_cmp = flag_z;
      CMP_NE:  o_ex_cmp = !flag_z;
      CMP_LT:  o_ex_cmp = cmp_signed_q ? (flag_n != flag_v) : !flag_c;
      default: o_ex_cmp = cmp_signed_q ? (flag_n == flag_v) : flag_c;
    endcase
  end

  // State register
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Slice counter, chained carry and zero accumulator; reset to fresh values after the last slice
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      ctr_q   <= '0;
      carry_q <= 1'b0;
      z_q     <= 1'b1;
    end else if (advance) begin
      ctr_q   <= last ? '0 : ctr_q + CTR_W'(1);
      carry_q <= last ? 1'b0 : cout;
      z_q     <= last ? 1'b1 : flag_z;
    end
  end

  // Op field capture on a predicated-true accept
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      alu_op_q     <= '0;
      rhs_inv_q    <= 1'b0;
      cin_q        <= 1'b0;
      cmp_op_q     <= '0;
      cmp_signed_q <= 1'b0;
    end else if (launch) begin
      alu_op_q     <= i_ex_alu_op;
      rhs_inv_q    <= i_ex_rhs_inv;
      cin_q        <= i_ex_cin;
      cmp_op_q     <= i_ex_cmp_op;
      cmp_signed_q <= i_ex_cmp_signed;
    end
  end

endmodule

// File: tb/tb_idli_ex_slice_m.sv
// Directed testbench for idli_ex_slice_m (DATA_W=16, SLICE_W=4).
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled
// on the falling edge.
module tb_idli_ex_slice_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_vld, op_acp, pred, rhs_inv, cin, cmp_signed, stall;
  logic [1:0] alu_op, cmp_op;
  logic [3:0] lhs, rhs, out_s;
  logic       out_vld, last, cmp;
  logic [1:0] ctr;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idli_ex_slice_m #(.DATA_W(16), .SLICE_W(4)) dut (
    .i_ex_gck(clk), .i_ex_rst_n(rst_n), .i_ex_op_vld(op_vld), .o_ex_op_acp(op_acp),
    .i_ex_pred(pred), .i_ex_alu_op(alu_op), .i_ex_rhs_inv(rhs_inv), .i_ex_cin(cin),
    .i_ex_cmp_op(cmp_op), .i_ex_cmp_signed(cmp_signed), .i_ex_lhs(lhs), .i_ex_rhs(rhs),
    .i_ex_stall(stall), .o_ex_out(out_s), .o_ex_out_vld(out_vld), .o_ex_ctr(ctr),
    .o_ex_last(last), .o_ex_flags(flags), .o_ex_cmp(cmp)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_drive();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [1:0] a_op, input logic inv, input logic c,
                        input logic [1:0] c_op, input logic sgn);
    alu_op = a_op; rhs_inv = inv; cin = c; cmp_op = c_op; cmp_signed = sgn;
  endtask

  // Issues one op, streams its four slices, and checks the result, flags and compare.
  // stall_at >= 0 inserts a 3-cycle stall on that slice.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] a_op, input logic inv, input logic c,
                        input logic [1:0] c_op, input logic sgn,
                        input logic [15:0] exp_res, input logic [3:0] exp_flags,
                        input logic exp_cmp, input int stall_at);
    logic [15:0] res;
    logic [3:0]  fl;
    logic        cm;
    res = '0; fl = '0; cm = 1'b0;
    next_drive();
    op_vld = 1'b1; pred = 1'b1; set_op(a_op, inv, c, c_op, sgn);
    @(negedge clk);
    check_val({tag, ".acp"}, op_acp, 1);
    next_drive();
    op_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lhs = a[i*4 +: 4]; rhs = b[i*4 +: 4];
`ifdef IDLI_EX_SLICE_STALL_EN
      if (i == stall_at) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_val({tag, ".stall_vld"}, out_vld, 0);
          check_val({tag, ".stall_ctr"}, ctr, i);
          next_drive();
        end
        stall = 1'b0;
      end
`endif
      @(negedge clk);
      check_val({tag, ".vld"}, out_vld, 1);
      check_val({tag, ".ctr"}, ctr, i);
      check_val({tag, ".last"}, last, (i == 3));
      res[i*4 +: 4] = out_s;
      if (i == 3) begin fl = flags; cm = cmp; end
      next_drive();
    end
    @(negedge clk);
    check_val({tag, ".idle_vld"}, out_vld, 0);
    check_val({tag, ".res"}, res, exp_res);
    check_val({tag, ".flags"}, fl, exp_flags);
    check_val({tag, ".cmp"}, cm, exp_cmp);
  endtask

  initial begin
    rst_n = 1'b0; op_vld = 1'b0; pred = 1'b1; stall = 1'b0;
    lhs = '0; rhs = '0;
    set_op(2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    #12;
    check_val("rst.acp", op_acp, 1);
    check_val("rst.vld", out_vld, 0);
    check_val("rst.last", last, 0);
    check_val("rst.ctr", ctr, 0);
    @(negedge clk); rst_n = 1'b1;

    // flags are {Z,N,C,V}
    run_op("add", 16'h1234, 16'h0FFF, 2'd0, 0, 0, 2'd0, 0, 16'h2233, 4'b0000, 0, -1);
    run_op("sub_eq", 16'h0005, 16'h0005, 2'd0, 1, 1, 2'd0, 0, 16'h0000, 4'b1010, 1, -1);
    run_op("sub_ne", 16'h0005, 16'h0005, 2'd0, 1, 1, 2'd1, 0, 16'h0000, 4'b1010, 0, -1);
    run_op("slt", 16'h8000, 16'h0001, 2'd0, 1, 1, 2'd2, 1, 16'h7FFF, 4'b0011, 1, -1);
    run_op("ult", 16'h8000, 16'h0001, 2'd0, 1, 1, 2'd2, 0, 16'h7FFF, 4'b0011, 0, -1);
    run_op("and", 16'hF0F0, 16'hFF00, 2'd1, 0, 0, 2'd2, 1, 16'hF000, 4'b0100, 1, -1);

    // back-to-back: A = F000+1000 ends with carry out, B = 0001+0001 with cin=0
    begin
      logic [15:0] ra, rb;
      logic [15:0] av, bv;
      ra = '0; rb = '0;
      next_drive();
      op_vld = 1'b1; pred = 1'b1; set_op(2'd0, 0, 0, 2'd0, 0);
      next_drive();
      set_op(2'd0, 0, 0, 2'd0, 0);
      for (int k = 0; k < 8; k++) begin
        av = (k < 4) ? 16'hF000 : 16'h0001;
        bv = (k < 4) ? 16'h1000 : 16'h0001;
        lhs = av[(k%4)*4 +: 4]; rhs = bv[(k%4)*4 +: 4];
        @(negedge clk);
        check_val("b2b.vld", out_vld, 1);
        check_val("b2b.ctr", ctr, k % 4);
        if (k < 4) begin
          check_val("b2b.acp", op_acp, (k == 3));
          ra[(k%4)*4 +: 4] = out_s;
        end else rb[(k%4)*4 +: 4] = out_s;
        if (k == 3) check_val("b2b.flags_a", flags, 4'b1010);
        if (k == 7) check_val("b2b.flags_b", flags, 4'b0000);
        next_drive();
        if (k == 3) op_vld = 1'b0;
      end
      @(negedge clk);
      check_val("b2b.idle", out_vld, 0);
      check_val("b2b.res_a", ra, 16'h0000);
      check_val("b2b.res_b", rb, 16'h0002);
    end

    // predicate drop
    next_drive();
    op_vld = 1'b1; pred = 1'b0; set_op(2'd3, 0, 1, 2'd0, 0);
    @(negedge clk);
    check_val("drop.acp", op_acp, 1);
    next_drive();
    op_vld = 1'b0; pred = 1'b1;
    @(negedge clk);
    check_val("drop.vld0", out_vld, 0);
    next_drive();
    @(negedge clk);
    check_val("drop.vld1", out_vld, 0);
    run_op("xor", 16'h00FF, 16'h0F0F, 2'd3, 0, 0, 2'd3, 0, 16'h0FF0, 4'b0000, 0, -1);

`ifdef IDLI_EX_SLICE_STALL_EN
    run_op("stall", 16'h1234, 16'h0FFF, 2'd0, 0, 0, 2'd0, 0, 16'h2233, 4'b0000, 0, 1);
`else
    stall = 1'b1;
    run_op("nostall", 16'h1234, 16'h0FFF, 2'd0, 0, 0, 2'd0, 0, 16'h2233, 4'b0000, 0, -1);
    stall = 1'b0;
`endif

    // reset mid-op at ctr=2
    next_drive();
    op_vld = 1'b1; pred = 1'b1; set_op(2'd0, 0, 0, 2'd0, 0);
    next_drive();
    op_vld = 1'b0;
    next_drive();
    next_drive();
    @(negedge clk);
    check_val("rmid.ctr2", ctr, 2);
    #1 rst_n = 1'b0;
    #1;
    check_val("rmid.vld", out_vld, 0);
    check_val("rmid.ctr", ctr, 0);
    check_val("rmid.acp", op_acp, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_val("rmid.idle", out_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/idli_ex_slice_m.md
Name: idli_ex_slice_m

Overview:
Parametrised slice-serial execute datapath, the next generation of the fixed 16b/4-slice execute stage. Processes a DATA_W operation as NUM_SLICES = DATA_W/SLICE_W slices, LSB slice first. Chains carry across slices, accumulates Z, and produces N/C/V plus a predicate compare result on the final slice. Adds a stall input, a predicate-skip drop path and back-to-back issue with no bubble.

Parameters:
DATA_W, 16, full operand width; must be a multiple of SLICE_W.
SLICE_W, 4, bits processed per cycle; NUM_SLICES >= 2.
CTR_W, $clog2(DATA_W/SLICE_W), slice counter width (derived; do not override).

Ports:
i_ex_gck  in  1  clock
i_ex_rst_n  in  1  reset
i_ex_op_vld  in  1  incoming op valid
o_ex_op_acp  out  1  incoming op accepted this cycle
i_ex_pred  in  1  predicate for incoming op; 0 drops the op
i_ex_alu_op  in  2  0 ADD, 1 AND, 2 OR, 3 XOR
i_ex_rhs_inv  in  1  invert RHS slices
i_ex_cin  in  1  carry-in for slice 0
i_ex_cmp_op  in  2  0 EQ, 1 NE, 2 LT, 3 GE
i_ex_cmp_signed  in  1  signed compare
i_ex_lhs  in  SLICE_W  LHS slice for op in flight
i_ex_rhs  in  SLICE_W  RHS slice for op in flight
i_ex_stall  in  1  freeze op in flight
o_ex_out  out  SLICE_W  result slice
o_ex_out_vld  out  1  o_ex_out valid and consumed this cycle
o_ex_ctr  out  CTR_W  current slice index
o_ex_last  out  1  final slice this cycle
o_ex_flags  out  4  {Z,N,C,V}; valid when o_ex_last && o_ex_out_vld
o_ex_cmp  out  1  compare result; valid with flags

Behaviour:
- Reset: i_ex_rst_n, asynchronous, active-low. Clears busy, ctr=0, carry_q=0, z_q=1; op fields X. Outputs out of reset: o_ex_op_acp=1, o_ex_out_vld=0, o_ex_last=0, o_ex_ctr=0.
- States: IDLE (busy=0), RUN (busy=1). Op is latched when i_ex_op_vld && o_ex_op_acp. Op goes busy only if i_ex_pred=1. Pred=0 latches nothing and stays IDLE.
- o_ex_op_acp = !busy || (o_ex_last && !i_ex_stall). Accepted in IDLE even during stall.
- Slices for the latched op are presented starting the cycle after acceptance. One slice per unstalled cycle.
- o_ex_out_vld = busy && !i_ex_stall. o_ex_last = busy && ctr==NUM_SLICES-1.
- Datapath (combinational from latched op + current slices): rhs' = rhs_inv ? ~rhs : rhs.
  - ADD: {cout,out} = lhs + rhs' + cin.
  - AND/OR/XOR: bitwise, cout=0.
  - cin = (ctr==0) ? op cin : carry_q. sign_cin = carry into bit SLICE_W-1.
- On an unstalled busy cycle: ctr++, wrapping to 0 after the last slice. carry_q <= cout (not on the last slice). z_q <= last ? 1 : z_q && (out==0).
- Last slice leaves RUN unless a new op is accepted that cycle, so back-to-back issue has zero bubbles. carry and Z are not carried between ops.
- Flags:
  - Z = z_q && (out==0).
  - N = out[SLICE_W-1].
  - C = cout.
  - V = (ADD) ? sign_cin ^ cout : 0.
- cmp:
  - EQ: Z.
  - NE: !Z.
  - LT: signed ? N!=V : !C.
  - GE: signed ? N==V : C.
- Stall: ctr, carry_q, z_q and busy hold. o_ex_out is still driven; o_ex_flags are not qualified.
- Reset mid-op aborts immediately; no partial flags are reported.

Optional Feature:
IDLI_EX_SLICE_STALL_EN. When defined, i_ex_stall behaves as above. When undefined, i_ex_stall is ignored (treated as 0). The port stays present and must be tied.

Test Plan:
1. DATA_W=16, SLICE_W=4, ADD 0x1234+0x0FFF, cin=0, pred=1 -> out slices 3,3,2,2 (0x2233) over 4 cycles; flags Z0 N0 C0 V0; o_ex_last only on ctr=3.
2. Subtract 0x0005-0x0005 (rhs_inv=1, cin=1), cmp EQ -> out 0x0000; Z1 C1 V0; cmp=1. Repeat with NE -> cmp=0.
3. 0x8000-0x0001 (rhs_inv=1, cin=1): signed LT -> result 0x7FFF, N0 V1, cmp=1; unsigned LT -> C=1, cmp=0.
4. Two ops back-to-back with i_ex_op_vld held: second accepted on first's ctr=3; o_ex_out_vld high 8 consecutive cycles; ctr wraps 3->0; second op uses its own cin (carry_q not leaked).
5. i_ex_pred=0 with i_ex_op_vld=1 -> o_ex_op_acp=1, op dropped, o_ex_out_vld stays 0. Following op with pred=1 executes normally.
6. With IDLI_EX_SLICE_STALL_EN: stall for 3 cycles at ctr=1 -> ctr holds 1, o_ex_out_vld=0, final result identical to unstalled run. Assert reset at ctr=2 -> o_ex_out_vld=0 and ctr=0 immediately, o_ex_op_acp=1.
